// File: rtl/note_scheduler_if.sv
// note_scheduler_if
//   Key-event handshake between the PS/2 key decoder (master) and the note
//   scheduler (slave). An event transfers on a cycle where iKeyValid and
//   oKeyReady are both high.
// Signals
//   iKeyValid  decoder -> scheduler  key event strobe
//   iKeyCode   decoder -> scheduler  decoded key code (KEY_W bits)
//   iKeyBreak  decoder -> scheduler  1 = release, 0 = press
//   oKeyReady  scheduler -> decoder  scheduler accepts an event this cycle
interface note_scheduler_if #(
  parameter int KEY_W = 8
);
  logic             iKeyValid;
  logic [KEY_W-1:0] iKeyCode;
  logic             iKeyBreak;
  logic             oKeyReady;

  modport master (
    output iKeyValid,
    output iKeyCode,
    output iKeyBreak,
    input  oKeyReady
  );

  modport slave (
    input  iKeyValid,
    input  iKeyCode,
    input  iKeyBreak,
    output oKeyReady
  );
endinterface

// File: rtl/note_scheduler.sv
// note_scheduler
//   Shares the single tone generator between simultaneously held piano keys.
//   Held keys live in a last-pressed-on-top stack; the top key is played.
//   A note plays for at least MIN_TICKS time-base ticks, and note changes and
//   note-off only happen on a completed tone period (iCycleDone).
// Ports
//   iClk          system clock, rising edge
//   iReset        asynchronous active-high reset
//   key           key-event handshake (slave side of note_scheduler_if)
//   iTick         1-cycle time-base strobe
//   iCycleDone    1-cycle pulse at the end of each tone period
//   oNote         key code for the frequency LUT, valid while oCountEnable=1
//   oCountEnable  tone divider/counter enable
//   oStackFull    stack holds DEPTH entries
//   oOverflow     sticky: a press evicted the oldest held key
module note_scheduler #(
  parameter int KEY_W     = 8,
  parameter int DEPTH     = 4,
  parameter int MIN_TICKS = 40,
  parameter int STOP_CODE = 99
) (
  input  logic              iClk,
  input  logic              iReset,
  note_scheduler_if.slave   key,
  input  logic              iTick,
  input  logic              iCycleDone,
  output logic [KEY_W-1:0]  oNote,
  output logic              oCountEnable,
  output logic              oStackFull,
  output logic              oOverflow
);

  localparam int                 CNT_W    = $clog2(DEPTH + 1);
  localparam int                 IDX_W    = $clog2(DEPTH);
  localparam logic [CNT_W-1:0]   FULL_CNT = CNT_W'(DEPTH);
  localparam logic [KEY_W-1:0]   STOP_KEY = KEY_W'(STOP_CODE);
  localparam logic [7:0]         MIN_LOAD = 8'(MIN_TICKS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PLAY,
    S_SWITCH,
    S_WAIT_MIN,
    S_DRAIN
  } state_t;

  // Entry 0 is the oldest key; entry r_count-1 is the top (most recent).
  logic [KEY_W-1:0] r_stack [DEPTH];
  logic [CNT_W-1:0] r_count;
  logic             r_ready;
  logic             r_overflow;
  logic             r_en;
  logic [KEY_W-1:0] r_note;
  logic [7:0]       r_min;
  state_t           r_state;

  logic             w_accept;
  logic             w_empty;
  logic             w_full;
  logic [IDX_W-1:0] w_top_idx;
  logic [KEY_W-1:0] w_top;
  logic             w_hit;
  logic [IDX_W-1:0] w_hit_idx;
  logic [KEY_W-1:0] w_stack_nxt [DEPTH];
  logic [CNT_W-1:0] w_count_nxt;
  logic             w_ovf_set;
  state_t           w_state_nxt;
  logic             w_load;
  logic             w_en_nxt;

  assign w_accept  = key.iKeyValid && r_ready;
  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == FULL_CNT);
  assign w_top_idx = w_empty ? '0 : IDX_W'(r_count - CNT_W'(1));
  assign w_top     = r_stack[w_top_idx];

  // Codes in the stack are unique, so at most one live entry can match.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_idx = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if ((CNT_W'(i) < r_count) && (r_stack[i] == key.iKeyCode)) begin
        w_hit     = 1'b1;
        w_hit_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    w_stack_nxt = r_stack;
    w_count_nxt = r_count;
    w_ovf_set   = 1'b0;
    if (w_accept) begin
      if (!key.iKeyBreak) begin
        if (key.iKeyCode == STOP_KEY) begin
          w_count_nxt = '0;
        end else if (!w_hit) begin
          if (w_full) begin
            // Evict the oldest entry: everything slides down one slot.
            for (int unsigned i = 0; i < DEPTH - 1; i++)
              w_stack_nxt[i] = r_stack[i+1];
            w_stack_nxt[DEPTH-1] = key.iKeyCode;
            w_ovf_set            = 1'b1;
          end else begin
            w_stack_nxt[IDX_W'(r_count)] = key.iKeyCode;
            w_count_nxt                  = r_count + CNT_W'(1);
          end
        end
      end else if (w_hit) begin
        // Close the gap left by the released key; stale slots above the
        // new count are never read.
        for (int unsigned i = 0; i < DEPTH - 1; i++)
          if (IDX_W'(i) >= w_hit_idx)
            w_stack_nxt[i] = r_stack[i+1];
        w_count_nxt = r_count - CNT_W'(1);
      end
    end
  end

  // Decisions use the stack as registered at the start of the cycle, so an
  // event accepted alongside iCycleDone is only seen at a later period end.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_en_nxt    = r_en;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_state_nxt = S_PLAY;
          w_load      = 1'b1;
          w_en_nxt    = 1'b1;
        end
      end
      S_PLAY: begin
        if (w_empty)
          w_state_nxt = S_WAIT_MIN;
        else if ((w_top != r_note) && (r_min == '0))
          w_state_nxt = S_SWITCH;
      end
      S_SWITCH: begin
        if (iCycleDone) begin
          if (w_empty) begin
            w_state_nxt = S_DRAIN;
          end else begin
            w_state_nxt = S_PLAY;
            w_load      = 1'b1;
          end
        end
      end
      S_WAIT_MIN: begin
        if (!w_empty)
          w_state_nxt = S_PLAY;
        else if (r_min == '0)
          w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (iCycleDone) begin
          w_state_nxt = S_IDLE;
          w_en_nxt    = 1'b0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_en_nxt    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      r_state    <= S_IDLE;
      r_stack    <= '{default: '0};
      r_count    <= '0;
      r_ready    <= 1'b1;
      r_overflow <= 1'b0;
      r_en       <= 1'b0;
      r_note     <= '0;
      r_min      <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_stack <= w_stack_nxt;
      r_count <= w_count_nxt;
      // One idle cycle after every accepted event.
      r_ready <= !w_accept;
      r_en    <= w_en_nxt;
      if (w_ovf_set)
        r_overflow <= 1'b1;
      if (w_load) begin
        r_note <= w_top;
        r_min  <= MIN_LOAD;
      end else if (iTick && (r_min != '0)) begin
        r_min <= r_min - 8'd1;
      end
    end
  end

  assign key.oKeyReady = r_ready;
  assign oNote         = r_note;
  assign oCountEnable  = r_en;
  assign oStackFull    = w_full;
  assign oOverflow     = r_overflow;

endmodule
